// File: rtl/pipe_pkg.sv
// Shared constants and types for the pipeline stage registers.
package pipe_pkg;

    // Flow-control flavours of pipe_stage_reg.
    localparam int MODE_LEGACY    = 0;
    localparam int MODE_HANDSHAKE = 1;

    // Width of the global stall vector and the stage positions inside it.
    localparam int STALL_W_DEFAULT = 6;

    typedef enum int {
        STAGE_IF  = 0,
        STAGE_ID  = 1,
        STAGE_IS  = 2,
        STAGE_EX  = 3,
        STAGE_MEM = 4,
        STAGE_WB  = 5
    } stage_e;

    // Per-edge action of the handshake-mode main/skid register pair.
    typedef enum logic [2:0] {
        SKID_IDLE,     // nothing moves
        SKID_LOAD_M,   // input goes straight into the main register
        SKID_LOAD_S,   // main is stuck, input parks in the skid register
        SKID_DRAIN_S,  // main leaves, skid moves up into main
        SKID_POP       // main leaves, nothing replaces it
    } skid_op_e;

    // Entries held by the main/skid pair; skid is only ever valid behind a valid main.
    function automatic logic [1:0] occ_count(input logic m_valid, input logic s_valid);
        return {s_valid, m_valid & ~s_valid};
    endfunction

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Upstream/downstream payload bus of one pipeline stage register.
interface pipe_stage_reg_if #(
    parameter int DATA_W = 64
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;

    // Environment side: feeds the stage and consumes its output.
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    // Stage side.
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear, used for stage performance statistics.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_inc,
    input  logic             i_clr,
    output logic [CNT_W-1:0] o_cnt
);
    logic [CNT_W-1:0] r_cnt;

    // Count up and stick at all-ones; reset beats clear, clear beats increment.
    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;
endmodule

// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register: legacy stall/flush or valid/ready with a skid entry.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int              DATA_W     = 64,
    parameter int              STALL_W    = STALL_W_DEFAULT,
    parameter int              STAGE_IDX  = int'(STAGE_MEM),
    parameter int              MODE       = MODE_LEGACY,
    parameter logic [DATA_W-1:0] BUBBLE_VAL = '0,
    parameter int              CNT_W      = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall,
    input  logic               flush,
    pipe_stage_reg_if.slave    bus,
    output logic [1:0]         occupancy,
    output logic [CNT_W-1:0]   stall_cnt,
    output logic [CNT_W-1:0]   bubble_cnt,
    input  logic               clr_cnt
);
    if (STAGE_IDX + 1 >= STALL_W) begin : g_bad_stage_idx
        $error("pipe_stage_reg: STAGE_IDX must leave room for the next stage's stall bit");
    end
    if ((MODE != MODE_LEGACY) && (MODE != MODE_HANDSHAKE)) begin : g_bad_mode
        $error("pipe_stage_reg: MODE must be 0 (legacy) or 1 (handshake)");
    end
    if ((DATA_W < 1) || (DATA_W > 512)) begin : g_bad_width
        $error("pipe_stage_reg: DATA_W must be in 1..512");
    end

    logic              w_m_valid;
    logic [DATA_W-1:0] w_m_data;
    logic              w_in_ready;
    logic [1:0]        w_occupancy;
    logic              w_stall_inc;
    logic              w_bubble_inc;

    // Each mode ignores one of these inputs entirely.
    logic w_unused;
    assign w_unused = ^{stall, bus.out_ready};

    if (MODE == MODE_LEGACY) begin : g_legacy
        logic              r_valid;
        logic [DATA_W-1:0] r_data;
        logic              w_adv;
        logic              w_bubble;
        logic              w_hold;

        assign w_adv    = ~stall[STAGE_IDX];
        assign w_bubble =  stall[STAGE_IDX] & ~stall[STAGE_IDX+1];
        assign w_hold   =  stall[STAGE_IDX] &  stall[STAGE_IDX+1];

        // Valid bit: flush and bubble empty the stage, advance copies upstream, hold keeps it.
        always_ff @(posedge clk) begin
            if (rst || flush || w_bubble) begin
                r_valid <= 1'b0;
            end else if (w_adv) begin
                r_valid <= bus.in_valid;
            end
        end

        // Payload capture on advance.
        // NOTE: payload flops carry no reset; the output mux substitutes BUBBLE_VAL whenever valid is low.
        always_ff @(posedge clk) begin
            if (w_adv) begin
                r_data <= bus.in_data;
            end
        end

        assign w_m_valid    = r_valid;
        assign w_m_data     = r_data;
        assign w_in_ready   = w_adv;
        assign w_occupancy  = {1'b0, r_valid};
        assign w_stall_inc  = ~flush & w_hold;
        assign w_bubble_inc = (~flush & w_bubble) | (flush & r_valid);
    end else begin : g_skid
        logic              r_m_valid;
        logic [DATA_W-1:0] r_m_data;
        logic              r_s_valid;
        logic [DATA_W-1:0] r_s_data;
        logic              w_in_xfer;
        logic              w_out_xfer;
        skid_op_e          w_op;

        assign w_in_xfer  = bus.in_valid & w_in_ready;
        assign w_out_xfer = r_m_valid & bus.out_ready;

        // Pick the single data movement for this edge; draining the skid entry wins.
        // NOTE: the default assignment first keeps this block free of inferred latches.
        always_comb begin
            w_op = SKID_IDLE;
            if (w_out_xfer && r_s_valid) begin
                w_op = SKID_DRAIN_S;
            end else if (w_in_xfer && (!r_m_valid || w_out_xfer)) begin
                w_op = SKID_LOAD_M;
            end else if (w_in_xfer) begin
                w_op = SKID_LOAD_S;
            end else if (w_out_xfer) begin
                w_op = SKID_POP;
            end
        end

        // Valid bits of main and skid; flush empties both at once.
        always_ff @(posedge clk) begin
            if (rst || flush) begin
                r_m_valid <= 1'b0;
                r_s_valid <= 1'b0;
            end else begin
                case (w_op)
                    SKID_LOAD_M:  r_m_valid <= 1'b1;
                    SKID_LOAD_S:  r_s_valid <= 1'b1;
                    SKID_DRAIN_S: r_s_valid <= 1'b0;
                    SKID_POP:     r_m_valid <= 1'b0;
                    default:      ;
                endcase
            end
        end

        // Payload movement between input, skid and main.
        always_ff @(posedge clk) begin
            case (w_op)
                SKID_LOAD_M:  r_m_data <= bus.in_data;
                SKID_LOAD_S:  r_s_data <= bus.in_data;
                SKID_DRAIN_S: r_m_data <= r_s_data;
                default:      ;
            endcase
        end

        assign w_m_valid    = r_m_valid;
        assign w_m_data     = r_m_data;
        // Ready comes straight from the skid flop; rst forces it low for the reset cycle.
        assign w_in_ready   = ~r_s_valid & ~rst;
        assign w_occupancy  = occ_count(r_m_valid, r_s_valid);
        assign w_stall_inc  = r_m_valid & ~bus.out_ready;
        assign w_bubble_inc = flush & (r_m_valid | r_s_valid);
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_m_valid;
    assign bus.out_data  = w_m_valid ? w_m_data : BUBBLE_VAL;
    assign occupancy     = w_occupancy;

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .i_inc (w_stall_inc),
        .i_clr (clr_cnt),
        .o_cnt (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
        .clk   (clk),
        .rst   (rst),
        .i_inc (w_bubble_inc),
        .i_clr (clr_cnt),
        .o_cnt (bubble_cnt)
    );
endmodule
